// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: register map, status bits, FSM states.
package uart_pkg;

  localparam logic [1:0] UART_REG_DATA   = 2'd0;
  localparam logic [1:0] UART_REG_STATUS = 2'd1;

  localparam int ST_AVAIL     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_FRAME_ERR = 3;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Peripheral bus shared by the UART blocks: register select, read and write strobes.
interface uart_rx_if;
  logic [2:0] addr;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       wr_en;
  logic [7:0] wr_data;

  modport master (output addr, rd_en, wr_en, wr_data, input rd_data, rd_valid);
  modport slave  (input addr, rd_en, wr_en, wr_data, output rd_data, rd_valid);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; a pop in the same cycle frees room for a push when full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             push_ok, pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_rx.sv
// Memory-mapped 8N1 UART receiver feeding an RX FIFO, with DATA/STATUS registers and level irq.
//   state | meaning
//   IDLE  | waiting for a falling edge on the synchronised line
//   START | timing to the start-bit midpoint to reject glitches
//   DATA  | sampling 8 data bits LSB-first at bit centres
//   STOP  | sampling the stop bit; push byte or flag frame error
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_rx_if.slave  bus,
  input  logic      rx,
  output logic      irq
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

  logic            sync1_q, rx_s_q, rx_prev_q;
  rx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      sh_q, sh_d;
  logic            overrun_q, overrun_d;
  logic            frame_err_q, frame_err_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic            irq_q, irq_d;

  logic            push, pop, frame_set, overrun_set;
  logic            fifo_full, fifo_empty;
  logic [7:0]      fifo_dout, status;
  logic [1:0]      reg_sel;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (sh_q),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // cnt is a down-counter; each phase reloads it and acts at terminal count zero
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    sh_d      = sh_q;
    push      = 1'b0;
    frame_set = 1'b0;
    if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
    unique case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          state_d = START;
          cnt_d   = CNT_HALF;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (!rx_s_q) begin
            state_d = DATA;
            cnt_d   = CNT_FULL;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          sh_d  = {rx_s_q, sh_q[7:1]};
          cnt_d = CNT_FULL;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          if (rx_s_q) push      = 1'b1;
          else        frame_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign reg_sel     = bus.addr[1:0];
  assign pop         = bus.rd_en && (reg_sel == UART_REG_DATA) && !fifo_empty;
  assign overrun_set = push && fifo_full && !pop;

  always_comb begin
    status               = '0;
    status[ST_AVAIL]     = !fifo_empty;
    status[ST_FULL]      = fifo_full;
    status[ST_OVERRUN]   = overrun_q;
    status[ST_FRAME_ERR] = frame_err_q;
  end

  // W1C clears are applied first so a same-cycle error event wins
  always_comb begin
    rd_valid_d  = bus.rd_en;
    rd_data_d   = '0;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    irq_d       = !fifo_empty;
    if (bus.rd_en) begin
      if (reg_sel == UART_REG_DATA && !fifo_empty) rd_data_d = fifo_dout;
      else if (reg_sel == UART_REG_STATUS)         rd_data_d = status;
    end
    if (bus.wr_en && reg_sel == UART_REG_STATUS) begin
      if (bus.wr_data[ST_OVERRUN])   overrun_d   = 1'b0;
      if (bus.wr_data[ST_FRAME_ERR]) frame_err_d = 1'b0;
    end
    if (overrun_set) overrun_d   = 1'b1;
    if (frame_set)   frame_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      sh_q        <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      sync1_q     <= rx;
      rx_s_q      <= sync1_q;
      rx_prev_q   <= rx_s_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sh_q        <= sh_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      irq_q       <= irq_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: framing, FIFO fill/overrun, errors, glitch, reset.
module tb_uart_rx;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic rx;
  logic irq;
  int   n_checks = 0;
  int   n_fail   = 0;

  uart_rx_if bus_if ();

  uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave),
    .rx    (rx),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    @(posedge clk);
    #1 rx = b;
    repeat (CPB - 1) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_bit);
    drive_bit(1'b1);
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d, output logic v);
    @(posedge clk);
    #1 bus_if.addr = a;
    bus_if.rd_en = 1'b1;
    @(posedge clk);
    #1 bus_if.rd_en = 1'b0;
    d = bus_if.rd_data;
    v = bus_if.rd_valid;
  endtask

  task automatic read_expect(input string tag, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] d;
    logic       v;
    bus_read(a, d, v);
    check({tag, "_valid"}, 32'(v), 32'd1);
    check(tag, 32'(d), 32'(exp));
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(posedge clk);
    #1 bus_if.addr = a;
    bus_if.wr_en   = 1'b1;
    bus_if.wr_data = d;
    @(posedge clk);
    #1 bus_if.wr_en = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    rx             = 1'b1;
    bus_if.addr    = '0;
    bus_if.rd_en   = 1'b0;
    bus_if.wr_en   = 1'b0;
    bus_if.wr_data = '0;

    // reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_valid", 32'(bus_if.rd_valid), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;
    read_expect("rst_status", 3'd1, 8'h00);
    read_expect("rst_data_empty", 3'd0, 8'h00);

    // single byte
    send_frame(8'hA5, 1'b1);
    check("single_irq", 32'(irq), 32'd1);
    read_expect("single_status", 3'd1, 8'h01);
    check("single_valid_idle", 32'(bus_if.rd_valid), 32'd1);
    @(posedge clk);
    #1 check("single_valid_drop", 32'(bus_if.rd_valid), 32'd0);
    read_expect("single_data", 3'd0, 8'hA5);
    read_expect("single_status_after", 3'd1, 8'h00);
    check("single_irq_clear", 32'(irq), 32'd0);

    // fill and overrun
    for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1);
    read_expect("fill_status", 3'd1, 8'h07);
    for (int i = 0; i < 8; i++) read_expect("fill_data", 3'd0, 8'(i));
    read_expect("fill_data_empty", 3'd0, 8'h00);
    read_expect("fill_status_ovr", 3'd1, 8'h04);
    check("fill_irq_clear", 32'(irq), 32'd0);
    bus_write(3'd1, 8'h08);
    read_expect("w1c_wrong_bit", 3'd1, 8'h04);
    bus_write(3'd1, 8'h04);
    read_expect("w1c_ovr", 3'd1, 8'h00);

    // frame error
    send_frame(8'h3C, 1'b0);
    read_expect("ferr_status", 3'd1, 8'h08);
    check("ferr_irq", 32'(irq), 32'd0);
    bus_write(3'd1, 8'h08);
    read_expect("ferr_clear", 3'd1, 8'h00);

    // glitch then good frame
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
    read_expect("glitch_status", 3'd1, 8'h00);
    check("glitch_irq", 32'(irq), 32'd0);
    send_frame(8'h5A, 1'b1);
    read_expect("glitch_next_data", 3'd0, 8'h5A);

    // reset in the middle of data bit 3 of 0xFF
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    @(posedge clk);
    #1 rx = 1'b1;
    repeat (CPB / 2) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6 * CPB) @(posedge clk);
    #1;
    read_expect("midrst_status", 3'd1, 8'h00);
    check("midrst_irq", 32'(irq), 32'd0);
    send_frame(8'h81, 1'b1);
    read_expect("midrst_next_data", 3'd0, 8'h81);
    read_expect("spare_addr", 3'd2, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
